// File: rtl/ldpc_shift_pkg.sv
// Shared definitions for the LDPC shift generators: default widths, frame
// state encoding and barrel-rotation direction.
package ldpc_shift_pkg;

    localparam int SHIFT_WIDTH_DEF = 9;
    localparam int REF_WIDTH_DEF   = 9;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } frame_state_t;

    typedef enum logic {
        FWD = 1'b0,
        REV = 1'b1
    } rot_dir_t;

endpackage

// File: rtl/shift_wrap_dir.sv
// Combinational wrap-around delta and shortest-rotation selection. The two
// halves are independent so the parent can register between them.
module shift_wrap_dir
    import ldpc_shift_pkg::*;
#(
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
    parameter int AW          = SHIFT_WIDTH + 1
) (
    input  logic [AW-1:0]          c,
    input  logic [AW-1:0]          prev,
    input  logic [AW-1:0]          w_cur,
    output logic [AW-1:0]          d,
    input  logic [AW-1:0]          d_reg,
    input  logic [AW-1:0]          w_reg,
    input  logic [AW-1:0]          half_reg,
    output logic [SHIFT_WIDTH-1:0] mag,
    output rot_dir_t               dir
);

    // c < W and prev < W, so c + W - prev never exceeds AW bits.
    always_comb begin
        d = c - prev;
        if (c < prev) begin
            d = c + w_cur - prev;
        end
    end

    always_comb begin
        mag = SHIFT_WIDTH'(d_reg);
        dir = FWD;
        if (d_reg > half_reg) begin
            mag = SHIFT_WIDTH'(w_reg - d_reg);
            dir = REV;
        end
    end

endmodule

// File: rtl/shift_delta_gen.sv
// Converts cumulative per-layer shifts into relative rotations (magnitude and
// direction) through a two-stage stallable pipeline with frame tracking.
module shift_delta_gen
    import ldpc_shift_pkg::*;
#(
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
    parameter int REF_WIDTH   = REF_WIDTH_DEF
) (
    input  logic                   sys_clk,
    input  logic                   rstn,
    input  logic [SHIFT_WIDTH-1:0] cum_shift_i,
    input  logic                   cum_valid_i,
    output logic                   cum_ready_o,
    input  logic                   cum_sof_i,
    input  logic                   cum_eof_i,
    input  logic [REF_WIDTH-1:0]   directRef_reconfig_i,
    input  logic [REF_WIDTH-1:0]   leqRef_reconfig_i,
    output logic [SHIFT_WIDTH-1:0] shift_mag_o,
    output logic                   shift_dir_o,
    output logic                   delta_valid_o,
    input  logic                   delta_ready_i,
    output logic                   delta_sof_o,
    output logic                   delta_eof_o,
    output logic                   range_err_o
);

    localparam int AW = SHIFT_WIDTH + 1;

    frame_state_t state_reg, state_next;
    logic         run_reg;
    logic [AW-1:0] w_reg, half_reg, prev_reg;

    logic          s1_valid_reg, s1_sof_reg, s1_eof_reg, s1_err_reg;
    logic [AW-1:0] s1_d_reg, s1_w_reg, s1_half_reg;

    logic                   s2_valid_reg, s2_sof_reg, s2_eof_reg, s2_err_reg;
    logic [SHIFT_WIDTH-1:0] s2_mag_reg;
    rot_dir_t               s2_dir_reg;

    logic          advance, accept, take, range_hit;
    logic [AW-1:0] w_in, half_in, w_cur, half_cur, prev_cur, cum_ext, c, d;
    logic [SHIFT_WIDTH-1:0] mag;
    rot_dir_t      dir;

    // run_reg keeps ready low during reset and for the release edge itself.
    assign advance     = run_reg & (~s2_valid_reg | delta_ready_i);
    assign cum_ready_o = advance;
    assign accept      = cum_valid_i & advance;
    assign take        = accept & (cum_sof_i | (state_reg == ACTIVE));

    always_comb begin
        w_in      = AW'(directRef_reconfig_i);
        half_in   = AW'(leqRef_reconfig_i);
        w_cur     = cum_sof_i ? w_in    : w_reg;
        half_cur  = cum_sof_i ? half_in : half_reg;
        prev_cur  = cum_sof_i ? '0      : prev_reg;
        cum_ext   = {1'b0, cum_shift_i};
        range_hit = (cum_ext >= w_cur);
        c         = range_hit ? (cum_ext - w_cur) : cum_ext;
    end

    shift_wrap_dir #(
        .SHIFT_WIDTH (SHIFT_WIDTH),
        .AW          (AW)
    ) u_wrap_dir (
        .c        (c),
        .prev     (prev_cur),
        .w_cur    (w_cur),
        .d        (d),
        .d_reg    (s1_d_reg),
        .w_reg    (s1_w_reg),
        .half_reg (s1_half_reg),
        .mag      (mag),
        .dir      (dir)
    );

    always_comb begin
        state_next = state_reg;
        if (accept) begin
            if (cum_sof_i) begin
                state_next = cum_eof_i ? IDLE : ACTIVE;
            end else if ((state_reg == ACTIVE) && cum_eof_i) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            run_reg   <= 1'b0;
            w_reg     <= '0;
            half_reg  <= '0;
            prev_reg  <= '0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
            if (take) begin
                prev_reg <= c;
                if (cum_sof_i) begin
                    w_reg    <= w_in;
                    half_reg <= half_in;
                end
            end
        end
    end

    // W and W/2 ride with the sample so a restart in stage 1 cannot
    // disturb the older sample finishing in stage 2.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_reg <= 1'b0;
            s1_sof_reg   <= 1'b0;
            s1_eof_reg   <= 1'b0;
            s1_err_reg   <= 1'b0;
            s1_d_reg     <= '0;
            s1_w_reg     <= '0;
            s1_half_reg  <= '0;
            s2_valid_reg <= 1'b0;
            s2_sof_reg   <= 1'b0;
            s2_eof_reg   <= 1'b0;
            s2_err_reg   <= 1'b0;
            s2_mag_reg   <= '0;
            s2_dir_reg   <= FWD;
        end else if (advance) begin
            s1_valid_reg <= take;
            s1_sof_reg   <= cum_sof_i;
            s1_eof_reg   <= cum_eof_i;
            s1_err_reg   <= range_hit;
            s1_d_reg     <= d;
            s1_w_reg     <= w_cur;
            s1_half_reg  <= half_cur;
            s2_valid_reg <= s1_valid_reg;
            s2_sof_reg   <= s1_sof_reg;
            s2_eof_reg   <= s1_eof_reg;
            s2_err_reg   <= s1_err_reg;
            s2_mag_reg   <= mag;
            s2_dir_reg   <= dir;
        end
    end

    assign delta_valid_o = s2_valid_reg;
    assign shift_mag_o   = s2_mag_reg;
    assign shift_dir_o   = s2_dir_reg;
    assign delta_sof_o   = s2_sof_reg;
    assign delta_eof_o   = s2_eof_reg;
    assign range_err_o   = s2_err_reg;

endmodule

// File: tb/tb_shift_delta_gen.sv
// Directed bench for shift_delta_gen: hand-computed (mag,dir,sof,eof,err)
// expectations are queued per input and compared in order as outputs appear.
module tb_shift_delta_gen;

    logic       sys_clk = 1'b0;
    logic       rstn    = 1'b0;
    logic [8:0] cum_shift_i = '0;
    logic       cum_valid_i = 1'b0;
    logic       cum_ready_o;
    logic       cum_sof_i = 1'b0;
    logic       cum_eof_i = 1'b0;
    logic [8:0] directRef_reconfig_i = 9'd15;
    logic [8:0] leqRef_reconfig_i    = 9'd7;
    logic [8:0] shift_mag_o;
    logic       shift_dir_o;
    logic       delta_valid_o;
    logic       delta_ready_i = 1'b1;
    logic       delta_sof_o;
    logic       delta_eof_o;
    logic       range_err_o;

    shift_delta_gen dut (
        .sys_clk              (sys_clk),
        .rstn                 (rstn),
        .cum_shift_i          (cum_shift_i),
        .cum_valid_i          (cum_valid_i),
        .cum_ready_o          (cum_ready_o),
        .cum_sof_i            (cum_sof_i),
        .cum_eof_i            (cum_eof_i),
        .directRef_reconfig_i (directRef_reconfig_i),
        .leqRef_reconfig_i    (leqRef_reconfig_i),
        .shift_mag_o          (shift_mag_o),
        .shift_dir_o          (shift_dir_o),
        .delta_valid_o        (delta_valid_o),
        .delta_ready_i        (delta_ready_i),
        .delta_sof_o          (delta_sof_o),
        .delta_eof_o          (delta_eof_o),
        .range_err_o          (range_err_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [12:0] val;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;
    bit   lat_en  = 1'b1;

    always @(posedge sys_clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the sample is taken.
    task automatic send(input logic [8:0] v, input logic s, input logic e,
                        input bit ex, input logic [8:0] m, input logic dr, input logic er);
        int  n = 0;
        bit  ok = 1'b0;
        cum_shift_i = v;
        cum_sof_i   = s;
        cum_eof_i   = e;
        cum_valid_i = 1'b1;
        while (!ok && n < 50) begin
            @(negedge sys_clk);
            if (cum_ready_o) ok = 1'b1;
            n++;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        $display("[TB] in  shift=%0d sof=%0d eof=%0d cycle=%0d", v, s, e, cycle);
        if (ok && ex) exp_q.push_back('{val: {m, dr, s, e, er}, acc: cycle, lat: lat_en});
        @(posedge sys_clk);
        #1;
        cum_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge sys_clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) begin
        if (rstn && delta_valid_o && delta_ready_i) begin
            $display("[TB] out mag=%0d dir=%0d sof=%0d eof=%0d err=%0d cycle=%0d",
                     shift_mag_o, shift_dir_o, delta_sof_o, delta_eof_o, range_err_o, cycle);
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_fields", {19'd0, shift_mag_o, shift_dir_o, delta_sof_o,
                                     delta_eof_o, range_err_o}, {19'd0, mon_e.val});
                if (mon_e.lat) check("latency", cycle - mon_e.acc, 32'd2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge sys_clk);
        check("reset_outs", {25'd0, cum_ready_o, delta_valid_o, shift_dir_o, delta_sof_o,
                             delta_eof_o, range_err_o, |shift_mag_o}, 32'd0);
        @(posedge sys_clk);
        #1 rstn = 1'b1;
        @(negedge sys_clk);
        check("ready_release0", cum_ready_o, 32'd0);
        @(negedge sys_clk);
        check("ready_release1", cum_ready_o, 32'd1);
        @(posedge sys_clk);
        #1;

        // Basic frame, W=15
        send(9'd0,  1, 0, 1, 9'd0, 0, 0);
        send(9'd3,  0, 0, 1, 9'd3, 0, 0);
        send(9'd10, 0, 0, 1, 9'd7, 0, 0);
        send(9'd4,  0, 1, 1, 9'd6, 1, 0);
        drain();

        // Samples without sof in IDLE are dropped
        send(9'd2, 0, 0, 0, 9'd0, 0, 0);
        send(9'd9, 0, 0, 0, 9'd0, 0, 0);
        send(9'd4, 1, 1, 1, 9'd4, 0, 0);
        drain();

        // Range reduction of 17 -> 2
        send(9'd0,  1, 0, 1, 9'd0, 0, 0);
        send(9'd17, 0, 1, 1, 9'd2, 0, 1);
        drain();

        // One-sample frame leaves FSM idle
        send(9'd12, 1, 1, 1, 9'd3, 1, 0);
        send(9'd4,  0, 0, 0, 9'd0, 0, 0);
        drain();

        // Backpressure for 4 cycles
        lat_en = 1'b0;
        delta_ready_i = 1'b0;
        fork
            begin
                send(9'd1,  1, 0, 1, 9'd1, 0, 0);
                send(9'd5,  0, 0, 1, 9'd4, 0, 0);
                send(9'd13, 0, 0, 1, 9'd7, 1, 0);
                send(9'd14, 0, 1, 1, 9'd1, 0, 0);
            end
            begin
                @(negedge sys_clk);
                check("stall_ready_a", cum_ready_o, 32'd1);
                @(negedge sys_clk);
                check("stall_ready_b", cum_ready_o, 32'd1);
                @(negedge sys_clk);
                check("stall_ready_c", cum_ready_o, 32'd0);
                @(negedge sys_clk);
                check("stall_ready_d", cum_ready_o, 32'd0);
                @(posedge sys_clk);
                #1 delta_ready_i = 1'b1;
            end
        join
        drain();
        lat_en = 1'b1;

        // W changes mid-frame: current frame keeps 15, next sof uses 7
        send(9'd0, 1, 0, 1, 9'd0, 0, 0);
        send(9'd3, 0, 0, 1, 9'd3, 0, 0);
        directRef_reconfig_i = 9'd7;
        leqRef_reconfig_i    = 9'd3;
        send(9'd12, 0, 0, 1, 9'd6, 1, 0);
        send(9'd2,  0, 1, 1, 9'd5, 0, 0);
        send(9'd5,  1, 0, 1, 9'd2, 1, 0);
        send(9'd1,  0, 1, 1, 9'd3, 0, 0);
        drain();
        directRef_reconfig_i = 9'd15;
        leqRef_reconfig_i    = 9'd7;

        // sof while active restarts the frame
        send(9'd2, 1, 0, 1, 9'd2, 0, 0);
        send(9'd6, 0, 0, 1, 9'd4, 0, 0);
        send(9'd9, 1, 0, 1, 9'd6, 1, 0);
        send(9'd1, 0, 1, 1, 9'd7, 0, 0);
        drain();

        // Reset with two samples in flight
        send(9'd3, 1, 0, 0, 9'd0, 0, 0);
        send(9'd6, 0, 0, 0, 9'd0, 0, 0);
        rstn = 1'b0;
        @(negedge sys_clk);
        check("midrst_outs", {25'd0, cum_ready_o, delta_valid_o, shift_dir_o, delta_sof_o,
                              delta_eof_o, range_err_o, |shift_mag_o}, 32'd0);
        @(posedge sys_clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        send(9'd7, 0, 0, 0, 9'd0, 0, 0);
        send(9'd8, 0, 1, 0, 9'd0, 0, 0);
        drain();
        send(9'd4, 1, 1, 1, 9'd4, 0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
